ram_sp_be_clr: RTL and testbench

RAM_SP_BE_CLR -- requirements
Module: ram_sp_be_clr

---
 rtl/ram_sp_be_clr.sv | 112 +++++++++++
 tb/tb_ram_sp_be_clr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_be_clr.sv
// Single-port RAM with per-lane write enables and a full-array clear sweep; reads have 1-cycle latency, read-first.
// No backpressure: while clr_busy_o/clr_done_o are up, read/write/clear requests are silently dropped.
module ram_sp_be_clr #(
  parameter int ADR_WD   = 8,
  parameter int DAT_WD   = 512,
  parameter int COL_WD   = 1,
  parameter int INIT_CLR = 1,
  localparam int EN_WD   = DAT_WD / COL_WD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADR_WD-1:0] adr_i,
  input  logic [EN_WD-1:0]  wr_ena_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  input  logic              rd_ena_i,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic              rd_val_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  localparam int DEPTH = 2 ** ADR_WD;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e            state_q, state_d;
  logic              arm_q;
  logic [ADR_WD-1:0] cnt_q, cnt_d;
  logic [DAT_WD-1:0] rd_dat_q, rd_dat_d;
  logic              rd_val_q, rd_val_d;
  logic              wipe_en;
  logic              acc_en;

  logic [DAT_WD-1:0] mem [DEPTH];

  // arm_q holds off the reset-time CLEAR state for the first edge after
  // release, so the sweep's busy window and its writes line up exactly.
  assign wipe_en = (state_q == CLEAR) && arm_q;
  assign acc_en  = rst_n && (state_q == IDLE) && !clr_start_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_dat_d = rd_dat_q;
    rd_val_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (rd_ena_i) begin
          rd_dat_d = mem[adr_i];
          rd_val_d = 1'b1;
        end
      end
      CLEAR: begin
        if (arm_q) begin
          cnt_d = cnt_q + ADR_WD'(1);
          if (cnt_q == '1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_CLR != 0) begin
        state_q <= CLEAR;
      end else begin
        state_q <= IDLE;
      end
      arm_q    <= 1'b0;
      cnt_q    <= '0;
      rd_dat_q <= '0;
      rd_val_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= 1'b1;
      cnt_q    <= cnt_d;
      rd_dat_q <= rd_dat_d;
      rd_val_q <= rd_val_d;
    end
  end

  // Storage is deliberately not reset; the clear sweep is the only way to zero it.
  always_ff @(posedge clk) begin
    if (wipe_en) begin
      mem[cnt_q] <= '0;
    end else if (acc_en) begin
      for (int k = 0; k < EN_WD; k++) begin
        if (wr_ena_i[k]) begin
          mem[adr_i][k*COL_WD +: COL_WD] <= wr_dat_i[k*COL_WD +: COL_WD];
        end
      end
    end
  end

  assign rd_dat_o   = rd_dat_q;
  assign rd_val_o   = rd_val_q;
  assign clr_busy_o = (state_q == CLEAR) && arm_q;
  assign clr_done_o = (state_q == DONE);

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Bench for ram_sp_be_clr: directed operations, a cycle-level reference model and a per-cycle output compare.
module tb_ram_sp_be_clr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  adr_i;
  logic [3:0]  wr_ena_i;
  logic [31:0] wr_dat_i;
  logic        rd_ena_i;
  logic [31:0] rd_dat_o;
  logic        rd_val_o;
  logic        clr_start_i;
  logic        clr_busy_o;
  logic        clr_done_o;

  int total = 0;
  int bad   = 0;

  ram_sp_be_clr #(
    .ADR_WD  (4),
    .DAT_WD  (32),
    .COL_WD  (8),
    .INIT_CLR(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adr_i      (adr_i),
    .wr_ena_i   (wr_ena_i),
    .wr_dat_i   (wr_dat_i),
    .rd_ena_i   (rd_ena_i),
    .rd_dat_o   (rd_dat_o),
    .rd_val_o   (rd_val_o),
    .clr_start_i(clr_start_i),
    .clr_busy_o (clr_busy_o),
    .clr_done_o (clr_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge-indexed. A clear that begins at edge E shows busy for
  // cycles E..E+15, done in cycle E+16, and requests are honoured again from edge E+18.
  logic [31:0] mm [16];
  logic [31:0] m_rd   = '0;
  logic        m_rv   = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          k_edge = 0;
  int          clr_edge = -1000;
  bit          arm = 1'b0;

  always @(posedge clk) begin
    k_edge++;
    if (!rst_n) begin
      m_rd     = '0;
      m_rv     = 1'b0;
      arm      = 1'b1;
      clr_edge = -1000;
    end else begin
      m_rv = 1'b0;
      if (arm) begin
        arm      = 1'b0;
        clr_edge = k_edge;
      end else if (k_edge >= clr_edge + 18) begin
        if (clr_start_i) begin
          clr_edge = k_edge;
        end else begin
          if (rd_ena_i) begin
            m_rd = mm[adr_i];
            m_rv = 1'b1;
          end
          for (int i = 0; i < 4; i++)
            if (wr_ena_i[i]) mm[adr_i][i*8 +: 8] = wr_dat_i[i*8 +: 8];
        end
      end
      if (k_edge == clr_edge + 16)
        for (int a = 0; a < 16; a++) mm[a] = '0;
    end
    m_busy = rst_n && (k_edge - clr_edge >= 0) && (k_edge - clr_edge <= 15);
    m_done = rst_n && (k_edge - clr_edge == 16);
  end

  always @(negedge clk) begin
    chk("cyc_rd_val", {31'd0, rd_val_o},   rst_n ? {31'd0, m_rv}   : 32'd0);
    chk("cyc_rd_dat", rd_dat_o,            rst_n ? m_rd            : 32'd0);
    chk("cyc_busy",   {31'd0, clr_busy_o}, rst_n ? {31'd0, m_busy} : 32'd0);
    chk("cyc_done",   {31'd0, clr_done_o}, rst_n ? {31'd0, m_done} : 32'd0);
  end

  // Called at posedge+1; applies one request which the next edge consumes.
  task automatic op(input logic [3:0] a, input logic [3:0] we, input logic [31:0] wd,
                    input logic rd, input logic cs);
    adr_i = a; wr_ena_i = we; wr_dat_i = wd; rd_ena_i = rd; clr_start_i = cs;
    @(posedge clk); #1;
    adr_i = '0; wr_ena_i = '0; wr_dat_i = '0; rd_ena_i = 1'b0; clr_start_i = 1'b0;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  // Counts busy cycles until the done pulse, poking rd_ena_i to show it is ignored.
  task automatic sweep(output int nb, output int nd);
    nb = 0; nd = 0;
    for (int i = 0; i < 60 && nd == 0; i++) begin
      @(negedge clk);
      if (clr_busy_o) nb++;
      if (clr_done_o) nd++;
      if (clr_busy_o || clr_done_o) chk("sweep_no_rd_val", {31'd0, rd_val_o}, 32'd0);
      @(posedge clk); #1;
      adr_i    = 4'd2;
      rd_ena_i = (nd == 0) ? i[0] : 1'b0;
    end
    rd_ena_i = 1'b0;
    adr_i    = '0;
    if (nd == 0) chk("sweep_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    op(a, 4'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk(name, rd_dat_o, exp);
    chk({name, "_val"}, {31'd0, rd_val_o}, 32'd1);
    realign();
  endtask

  initial begin
    int nb, nd;
    rst_n = 1'b0; adr_i = '0; wr_ena_i = '0; wr_dat_i = '0;
    rd_ena_i = 1'b0; clr_start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_dat", rd_dat_o, 32'h0);
    chk("rst_rd_val", {31'd0, rd_val_o}, 32'd0);
    chk("rst_busy",   {31'd0, clr_busy_o}, 32'd0);
    chk("rst_done",   {31'd0, clr_done_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    sweep(nb, nd);
    chk("init_busy_len", nb, 32'd16);
    chk("init_done_cnt", nd, 32'd1);
    for (int a = 0; a < 16; a++) read_chk("init_zero", 4'(a), 32'h0);

    op(4'd3, 4'hF, 32'hAABB_CCDD, 1'b0, 1'b0);
    op(4'd3, 4'b0101, 32'h1122_3344, 1'b0, 1'b0);
    read_chk("lane_merge", 4'd3, 32'hAA22_CC44);
    @(negedge clk);
    chk("rd_val_one_cycle", {31'd0, rd_val_o}, 32'd0);
    chk("rd_dat_hold", rd_dat_o, 32'hAA22_CC44);
    realign();

    op(4'd5, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    chk("read_first_old", rd_dat_o, 32'h0);
    realign();
    read_chk("read_first_new", 4'd5, 32'hFFFF_FFFF);
    op(4'd9, 4'h0, 32'h5555_5555, 1'b0, 1'b0);
    read_chk("no_lane_write", 4'd9, 32'h0);

    op(4'd2, 4'hF, 32'h0000_1234, 1'b1, 1'b1);
    sweep(nb, nd);
    chk("clr_busy_len", nb, 32'd16);
    chk("clr_done_cnt", nd, 32'd1);
    read_chk("clr_drop_wr", 4'd2, 32'h0);
    read_chk("clr_adr3", 4'd3, 32'h0);
    read_chk("clr_adr5", 4'd5, 32'h0);

    op(4'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    read_chk("pre_abort", 4'd0, 32'hDEAD_BEEF);
    op(4'd0, 4'h0, 32'h0, 1'b0, 1'b1);
    repeat (7) realign();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rd_dat", rd_dat_o, 32'h0);
    chk("abort_busy",   {31'd0, clr_busy_o}, 32'd0);
    chk("abort_done",   {31'd0, clr_done_o}, 32'd0);
    realign();
    realign();
    rst_n = 1'b1;
    sweep(nb, nd);
    chk("restart_busy_len", nb, 32'd16);
    chk("restart_done_cnt", nd, 32'd1);
    read_chk("restart_adr0", 4'd0, 32'h0);
    read_chk("restart_adr15", 4'd15, 32'h0);

    repeat (2) realign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
